// File: rtl/relogio_pkg.sv
// Shared definitions for the clock chain: hour width and limits, the adjust
// FSM state type, and the 24h-to-12h mapping used when HORAS_12H_EN is set.
package relogio_pkg;

    localparam int HORAS_W = 5;
    localparam logic [HORAS_W-1:0] HORAS_MAX = 5'd23;
    localparam logic [HORAS_W:0] HORAS_MOD = 6'd24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        REPEAT = 2'd2
    } adj_state_t;

    // Returns {pm, hour12}: 0 -> 12 AM, 1..11 AM, 12 -> 12 PM, 13..23 -> h-12 PM
    function automatic logic [4:0] hora_12h(input logic [HORAS_W-1:0] h);
        logic [4:0] r;
        if (h == 5'd0) begin
            r = {1'b0, 4'd12};
        end else if (h < 5'd12) begin
            r = {1'b0, h[3:0]};
        end else if (h == 5'd12) begin
            r = {1'b1, 4'd12};
        end else begin
            r = {1'b1, 4'(h - 5'd12)};
        end
        return r;
    endfunction

endpackage

// File: rtl/ajuste_botao.sv
// Adjust push-button front end: 2-flop synchronizer, rising-edge detect and a
// hold-to-auto-repeat FSM. Emits a one-cycle step pulse for every adjust step.
module ajuste_botao
    import relogio_pkg::*;
#(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 12_500_000
) (
    input  logic clk_i,
    input  logic rstn_i,
    input  logic adj_i,
    output logic step_o
);

    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    logic [1:0]       sync_r;
    logic             adj_s;
    logic             adj_prev_r;
    adj_state_t       state_r;
    adj_state_t       state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_s;
    logic             step_s;

    assign adj_s  = sync_r[1];
    assign step_o = step_s;

    // Synchronize the raw button and keep last cycle's synchronized level for edge detect
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_r     <= 2'b00;
            adj_prev_r <= 1'b0;
        end else begin
            sync_r     <= {sync_r[0], adj_i};
            adj_prev_r <= sync_r[1];
        end
    end

    // FSM state and shared hold/repeat counter
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_r <= IDLE;
            cnt_r   <= '0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
        end
    end

    // Next state, counter and step: first step on press, then after hold, then every repeat period
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        step_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (adj_s && !adj_prev_r) begin
                    step_s  = 1'b1;
                    state_s = HOLD;
                    cnt_s   = '0;
                end else begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end
            end
            HOLD: begin
                if (adj_s) begin
                    if (cnt_r == HOLD_LAST) begin
                        step_s  = 1'b1;
                        state_s = REPEAT;
                        cnt_s   = '0;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end
            end
            REPEAT: begin
                if (adj_s) begin
                    if (cnt_r == REPEAT_LAST) begin
                        step_s = 1'b1;
                        cnt_s  = '0;
                    end else begin
                        cnt_s = cnt_r + CNT_W'(1);
                    end
                end else begin
                    state_s = IDLE;
                    cnt_s   = '0;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
    end

endmodule

// File: rtl/horas.sv
// Hour stage (0-23) of the clock chain: counts minute carries, adds manual
// adjust steps, and emits a registered one-cycle day carry on a carry wrap.
// Optional macro HORAS_12H_EN adds registered 12-hour outputs horas12_o/pm_o.
module horas
    import relogio_pkg::*;
#(
    parameter int HOLD_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 12_500_000
) (
    input  logic               clk_i,
    input  logic               rstn_i,
    input  logic               inc_hora_i,
    input  logic               adj_i,
    output logic [HORAS_W-1:0] horas_o,
    output logic               inc_dia_o
`ifdef HORAS_12H_EN
    ,
    output logic [3:0]         horas12_o,
    output logic               pm_o
`endif
);

    logic               step_s;
    logic [HORAS_W:0]   sum_s;
    logic [HORAS_W:0]   red1_s;
    logic [HORAS_W-1:0] next_s;
    logic               dia_s;
    logic [HORAS_W-1:0] horas_r;
    logic               dia_r;

    ajuste_botao #(
        .HOLD_CYCLES  (HOLD_CYCLES),
        .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ajuste (
        .clk_i (clk_i),
        .rstn_i(rstn_i),
        .adj_i (adj_i),
        .step_o(step_s)
    );

    // Carry and adjust combine into one 6-bit sum, folded back into 0..23;
    // only a carry out of 23 produces a day carry
    always_comb begin
        sum_s = {1'b0, horas_r} + {5'b0, inc_hora_i} + {5'b0, step_s};
        if (sum_s >= HORAS_MOD) begin
            red1_s = sum_s - HORAS_MOD;
        end else begin
            red1_s = sum_s;
        end
        if (red1_s >= HORAS_MOD) begin
            next_s = 5'(red1_s - HORAS_MOD);
        end else begin
            next_s = 5'(red1_s);
        end
        if (inc_hora_i && (horas_r == HORAS_MAX)) begin
            dia_s = 1'b1;
        end else begin
            dia_s = 1'b0;
        end
    end

    // Hour counter and day-carry registers
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            horas_r <= '0;
            dia_r   <= 1'b0;
        end else begin
            horas_r <= next_s;
            dia_r   <= dia_s;
        end
    end

    assign horas_o   = horas_r;
    assign inc_dia_o = dia_r;

`ifdef HORAS_12H_EN
    logic [3:0] h12_r;
    logic       pm_r;

    // 12-hour view registered from the same next value as the hour counter
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            h12_r <= 4'd12;
            pm_r  <= 1'b0;
        end else begin
            {pm_r, h12_r} <= hora_12h(next_s);
        end
    end

    assign horas12_o = h12_r;
    assign pm_o      = pm_r;
`endif

endmodule

// File: tb/tb_horas.sv
// Self-checking bench for horas with HOLD_CYCLES=4, REPEAT_CYCLES=2.
// A behavioural model tracks the expected hour from carry pulses and from
// adjust steps derived from button timing rules (2-edge sync latency, step on
// press, then after HOLD, then every REPEAT while held).
module tb_horas;

    localparam int HOLD = 4;
    localparam int REP  = 2;

    logic       clk = 1'b0;
    logic       rstn;
    logic       inc_hora;
    logic       adj;
    logic [4:0] horas_o;
    logic       inc_dia_o;
`ifdef HORAS_12H_EN
    logic [3:0] horas12_o;
    logic       pm_o;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int exp_h;
    bit exp_dia;
    bit d1, d2, s_prev;
    int run;
    int dia_count;
    bit adj_lvl;

    horas #(
        .HOLD_CYCLES  (HOLD),
        .REPEAT_CYCLES(REP)
    ) dut (
        .clk_i     (clk),
        .rstn_i    (rstn),
        .inc_hora_i(inc_hora),
        .adj_i     (adj),
        .horas_o   (horas_o),
        .inc_dia_o (inc_dia_o)
`ifdef HORAS_12H_EN
        ,
        .horas12_o (horas12_o),
        .pm_o      (pm_o)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        assert (got === want) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic model_reset();
        exp_h   = 0;
        exp_dia = 1'b0;
        d1      = 1'b0;
        d2      = 1'b0;
        s_prev  = 1'b0;
        run     = 0;
    endtask

    task automatic check_outputs();
        check("horas", 32'(horas_o), exp_h);
        check("inc_dia", 32'(inc_dia_o), 32'(exp_dia));
`ifdef HORAS_12H_EN
        check("horas12", 32'(horas12_o), (exp_h == 0) ? 12 : ((exp_h > 12) ? exp_h - 12 : exp_h));
        check("pm", 32'(pm_o), (exp_h >= 12) ? 1 : 0);
`endif
    endtask

    // Effect of one rising edge: button level seen by the adjust logic is the
    // input sampled two edges earlier
    task automatic model_edge(input bit inc_v, input bit adj_v);
        bit s_cur;
        bit step;
        s_cur = d2;
        step  = 1'b0;
        if (s_cur) begin
            if (!s_prev) begin
                step = 1'b1;
                run  = 0;
            end else begin
                run++;
                if (run == HOLD || (run > HOLD && ((run - HOLD) % REP) == 0)) step = 1'b1;
            end
        end
        s_prev  = s_cur;
        d2      = d1;
        d1      = adj_v;
        exp_dia = inc_v && (exp_h == 23);
        exp_h   = (exp_h + int'(inc_v) + int'(step)) % 24;
    endtask

    // One clock cycle, entered and left at a falling edge
    task automatic cycle(input bit inc_v, input bit adj_v);
        inc_hora = inc_v;
        adj      = adj_v;
        @(posedge clk);
        model_edge(inc_v, adj_v);
        #1;
        check_outputs();
        if (inc_dia_o === 1'b1) dia_count++;
        @(negedge clk);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must clear at once
    task automatic do_reset();
        #2;
        rstn     = 1'b0;
        inc_hora = 1'b0;
        adj      = 1'b0;
        model_reset();
        #1;
        check_outputs();
        @(negedge clk);
        rstn = 1'b1;
    endtask

    task automatic goto_hour(input int target);
        for (int i = 0; i < 24; i++) begin
            if (exp_h != target) cycle(1'b1, 1'b0);
        end
    endtask

    initial begin
        rstn     = 1'b0;
        inc_hora = 1'b0;
        adj      = 1'b0;
        model_reset();
        @(negedge clk);
        do_reset();

        // 24 carries: 0..23 then 0, exactly one day carry
        dia_count = 0;
        for (int i = 0; i < 24; i++) cycle(1'b1, 1'b0);
        check("wrap_hour", 32'(horas_o), 0);
        cycle(1'b0, 1'b0);
        check("dia_once", dia_count, 1);

        // Carry and adjust step coincide at 22 and at 23
        goto_hour(22);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        check("both_22_h", 32'(horas_o), 0);
        check("both_22_dia", 32'(inc_dia_o), 0);
        goto_hour(23);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        cycle(1'b1, 1'b0);
        check("both_23_h", 32'(horas_o), 1);
        check("both_23_dia", 32'(inc_dia_o), 1);

        // Single-cycle press from 5
        goto_hour(5);
        cycle(1'b0, 1'b1);
        cycle(1'b0, 1'b0);
        check("tap_before", 32'(horas_o), 5);
        cycle(1'b0, 1'b0);
        check("tap_step", 32'(horas_o), 6);
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0);
        check("tap_final", 32'(horas_o), 6);

        // 12-cycle hold from 0: steps at +0,+4,+6,+8,+10
        do_reset();
        for (int i = 0; i < 12; i++) cycle(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0);
        check("hold_final", 32'(horas_o), 5);

        // Reset in REPEAT at 17 discards progress
        goto_hour(15);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b1);
        check("pre_rst_17", 32'(horas_o), 17);
        do_reset();
        check("rst_h", 32'(horas_o), 0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0);
        check("post_rst_h", 32'(horas_o), 0);
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1);
        check("fresh_press", 32'(horas_o), 1);

        // Randomized carries and button activity
        adj_lvl = 1'b0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 9) == 0) adj_lvl = ~adj_lvl;
            cycle($urandom_range(0, 3) == 0, adj_lvl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/horas.md
# horas

Hour stage of the clock chain, directly downstream of the minutes counter. Counts 0–23 on single-cycle carry pulses from the minutes stage and emits a one-cycle day-carry pulse on wrap. Also provides manual hour adjustment from an asynchronous push-button, with synchronizer, press detection and hold-to-auto-repeat.

## Interface
- HOLD_CYCLES, default 50_000_000: cycles the button must stay held after the first step before auto-repeat starts; ≥2.
- REPEAT_CYCLES, default 12_500_000: cycles between auto-repeat steps; ≥2.
- clk_i  input  1  clock.
- rstn_i  input  1  reset, asynchronous, active-low.
- inc_hora_i  input  1  carry pulse from the minutes stage, one cycle wide.
- adj_i  input  1  raw adjust button, asynchronous, active-high; pre-debounced externally.
- horas_o  output  5  current hour, 0–23.
- inc_dia_o  output  1  registered day-carry pulse.
- horas12_o  output  4  12-hour value, 1–12; present only with HORAS_12H_EN.
- pm_o  output  1  high for hours 12–23; present only with HORAS_12H_EN.

## Operation
- Reset values: horas_o=0, inc_dia_o=0, horas12_o=12, pm_o=0. Synchronizer flops and adjust FSM go to 0/IDLE.
- On reset, counters clear and the FSM returns to IDLE; reset mid-hold discards any repeat progress.
- Carry increment (inc_hora_i=1):
  - horas_o+1, wrapping 23→0.
  - On that wrap, inc_dia_o=1 for exactly one cycle; otherwise inc_dia_o=0 every cycle.
- Adjust input:
  - adj_i passes through a 2-flop synchronizer. The FSM sees only the second-stage value (adj_s).
  - Each adjust step adds 1 to horas_o with the same 23→0 wrap.
  - Adjust steps never assert inc_dia_o.
- Adjust FSM states: IDLE, HOLD, REPEAT; one internal counter wide enough for max(HOLD_CYCLES, REPEAT_CYCLES).
  - IDLE, adj_s rising (adj_s=1, previous=0): issue one step, go to HOLD, clear counter.
  - HOLD, adj_s=1: counter increments. At counter==HOLD_CYCLES-1: issue step, go to REPEAT, clear counter.
  - REPEAT, adj_s=1: counter increments. At counter==REPEAT_CYCLES-1: issue step, clear counter.
  - HOLD or REPEAT, adj_s=0: go to IDLE the next edge; no step.
- Simultaneous carry and adjust step in one cycle: net +2 mod 24.
  - Carry is applied first. inc_dia_o is asserted only if the old value was 23.
  - Old value 22: result 0, no inc_dia_o.
- Arithmetic: internal sum is 6 bits wide, reduced mod 24 by at most two conditional subtractions. horas_o never holds 24–31.

## Timing
- inc_hora_i high at edge N:
  - horas_o shows the new value after edge N.
  - inc_dia_o is high for the cycle following edge N.
- Both outputs are registered; there is no combinational path from any input to any output.
- adj_i first sampled high at edge N: first step appears on horas_o after edge N+2 (two synchronizer edges plus the update edge).
- Continuous hold:
  - Second step lands HOLD_CYCLES cycles after the first.
  - Each later step lands REPEAT_CYCLES cycles after the previous one.
- Release sampled low by the synchronizer at edge M: no step after edge M+1.

## Configuration
- HORAS_12H_EN defined:
  - horas12_o and pm_o exist and are registered, updated on the same edge as horas_o.
  - Mapping: 0→12 AM, 1–11→same AM, 12→12 PM, 13–23→minus 12 PM.
- HORAS_12H_EN undefined: both ports and their logic are absent; all other behaviour is unchanged.

## Structure
- Shared package relogio_pkg holds:
  - HORAS_MAX=23 and the hour width (5).
  - typedef enum adj_state_t {IDLE, HOLD, REPEAT}.
- Sub-module ajuste_botao holds the synchronizer, edge detect and hold/repeat FSM. It is parameterized by HOLD_CYCLES and REPEAT_CYCLES and outputs a one-cycle step pulse.
- horas instantiates ajuste_botao once and owns the counter, wrap and day carry.

## Test plan
Run with HOLD_CYCLES=4, REPEAT_CYCLES=2.
- Reset release, then 24 carry pulses → horas_o steps 0…23 then 0; inc_dia_o high exactly once, the cycle after the 24th pulse.
- horas_o=22; carry and adjust step in the same cycle → horas_o=0, inc_dia_o stays 0. Repeat from 23 → horas_o=1, inc_dia_o=1.
- adj_i high for 1 cycle from horas_o=5 → horas_o=6 two edges later; no further change.
- adj_i held 12 cycles from 0 → steps at sync+0, +4, +6, +8, +10 → final horas_o=5; no step after release.
- Assert rstn_i low mid-REPEAT with horas_o=17 → outputs return to reset values immediately; next step needs a fresh press.
- HORAS_12H_EN: hours 0, 11, 12, 13, 23 → horas12_o/pm_o = 12/0, 11/0, 12/1, 1/1, 11/1.
